seq_alu: RTL and testbench
==========================

# seq_alu

Registered, handshaked execution unit that consumes the 3-bit ALU control code produced by the ALU control decoder, together with the two operands from the register-read/forwarding stage. Logic ops and ADD/SUB complete in one cycle; MUL runs as an iterative shift-add multiplier over WIDTH cycles. While a multiply is in progress, `ready_o` deasserts so the pipeline control can stall the issue stage.

## Interface
- WIDTH, 32, operand and result width in bits
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  operands and code present this cycle
- ready_o  output  1  unit can accept; combinational, high only in IDLE with `rst_i` low
- ALUCtrl_i  input  3  operation code: 010 ADD, 110 SUB, 000 AND, 001 OR, 011 MUL; all others illegal
- data1_i  input  WIDTH  operand A (rs)
- data2_i  input  WIDTH  operand B (rt or immediate)
- valid_o  output  1  one-cycle pulse; result registers updated this cycle
- data_o  output  WIDTH  result, held until the next result
- zero_o  output  1  registered (result == 0), updated with `data_o`
- illegal_o  output  1  registered; set when the last accepted code was illegal

## Operation
- Accept occurs on a rising edge with `valid_i && ready_o`. When not ready, `valid_i` is ignored and the producer holds its inputs.
- States:
  - IDLE: accept → DONE-path for single-cycle codes, or MUL for 011.
  - MUL: runs WIDTH iterations → IDLE.
- ADD/SUB: modulo 2^WIDTH. No carry or overflow output.
- AND/OR: bitwise.
- Illegal code: `data_o`=0, `zero_o`=1, `illegal_o`=1, completes as a single-cycle op.
- `illegal_o` is cleared by any legal completion.
- MUL:
  - On accept, load multiplicand=`data1_i`, multiplier=`data2_i`, acc=0, count=0.
  - Each MUL-state edge: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - After the iteration with count==WIDTH-1, write acc to `data_o` and return to IDLE.
  - The result is the low WIDTH bits of the product, which are identical for signed and unsigned operands.
  - There is no early termination, so latency is fixed.
- Reset values: state IDLE, `data_o`=0, `zero_o`=0, `illegal_o`=0, `valid_o`=0, and internal multiplier registers 0.
- Reset mid-multiply abandons the operation; no `valid_o` is produced for it.

## Timing
- Single-cycle op accepted at edge N: `valid_o`=1 during cycle N→N+1, with `data_o`/`zero_o` valid in the same cycle. `ready_o` stays high, so back-to-back accepts give one result per cycle.
- MUL accepted at edge N:
  - `ready_o` is low from after edge N until edge N+WIDTH.
  - `valid_o` pulses in the cycle after edge N+WIDTH.
  - `ready_o` is high again in that same cycle, so the next op can be accepted at edge N+WIDTH+1.
  - Throughput is one MUL per WIDTH+1 cycles.
- `valid_o` is never high for two consecutive cycles from the same op. There is no downstream backpressure: the consumer must sample on the pulse.
- `rst_i` high at an edge overrides any accept at that edge.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL is supported as described above.
- `SEQ_ALU_MUL_EN` undefined:
  - Code 011 is treated as illegal: single cycle, `data_o`=0, `illegal_o`=1.
  - The MUL state and multiplier registers are not instantiated, and `ready_o` is constantly high except during reset.

## Structure
- `seq_alu_pkg`:
  - Localparams for the five ALU codes (shared with the ALU control decoder).
  - State encoding (IDLE, MUL).
- Sub-module `seq_alu_mul`:
  - The iterative shift-add datapath: start, operands, done pulse, product.
  - Instantiated only under `SEQ_ALU_MUL_EN`.
- The top level holds the FSM, the single-cycle datapath and the output registers.

## Test plan (WIDTH=32)
- ADD 0x7FFFFFFF + 0x00000001 → `data_o`=0x80000000, `zero_o`=0, `valid_o` one cycle after accept. SUB 5−5 → `data_o`=0, `zero_o`=1.
- Back-to-back AND 0xF0F0F0F0&0xFF00FF00 then OR of the same operands on consecutive edges → results 0xF000F000 then 0xFFF0FFF0 on consecutive cycles, `ready_o` always 1.
- MUL 0xFFFFFFFF×0x00000003 → `ready_o` low for 32 cycles, `valid_o` in the cycle after edge N+32, `data_o`=0xFFFFFFFD. A `valid_i` held during busy is accepted only on the first ready edge.
- Illegal code 111 with operands 3, 4 → `data_o`=0, `zero_o`=1, `illegal_o`=1. A following ADD 3+4 → `data_o`=7, `illegal_o`=0.
- `rst_i` asserted 10 cycles into MUL 6×7 → no `valid_o`, all outputs 0, `ready_o` high the cycle after `rst_i` drops. A new MUL 6×7 then gives 42.
- Build without `SEQ_ALU_MUL_EN`: MUL 6×7 → one-cycle `valid_o`, `data_o`=0, `illegal_o`=1, `ready_o` never low.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared ALU control codes and FSM state encoding for seq_alu.
package seq_alu_pkg;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluMul = 3'b011;
  localparam logic [2:0] AluSub = 3'b110;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Issue/result bundle for seq_alu; signal names are from the unit's point of view.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             illegal_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  ready_o, valid_o, data_o, zero_o, illegal_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output ready_o, valid_o, data_o, zero_o, illegal_o
  );
endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per step, low WIDTH bits of the product.
module seq_alu_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CntW-1:0]  r_count;
  logic [WIDTH-1:0] w_acc_next;

  always_comb begin
    w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (start_i) begin
      r_mcand  <= a_i;
      r_mplier <= b_i;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (step_i) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CntW'(1);
    end
  end

  // Product is taken from the final step's sum so it lands on the same edge as the last iteration.
  assign done_o    = step_i && (r_count == LastCnt);
  assign product_o = w_acc_next;

endmodule

// File: rtl/seq_alu.sv
// Registered handshaked ALU: single-cycle ADD/SUB/AND/OR, iterative MUL when
// SEQ_ALU_MUL_EN is defined (otherwise code 011 is treated as illegal).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk_i,
  input logic     rst_i,
  seq_alu_if.slave bus
);

  logic             w_accept;
  logic             w_is_mul;
  logic             w_illegal;
  logic [WIDTH-1:0] w_result;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_product;

  logic             r_valid, w_valid_d;
  logic [WIDTH-1:0] r_data,  w_data_d;
  logic             r_zero,  w_zero_d;
  logic             r_illegal, w_illegal_d;

  always_comb begin
    w_illegal = 1'b0;
    w_result  = '0;
    case (bus.ALUCtrl_i)
      AluAdd:  w_result = bus.data1_i + bus.data2_i;
      AluSub:  w_result = bus.data1_i - bus.data2_i;
      AluAnd:  w_result = bus.data1_i & bus.data2_i;
      AluOr:   w_result = bus.data1_i | bus.data2_i;
`ifdef SEQ_ALU_MUL_EN
      AluMul:  w_result = '0;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  state_e r_state, w_state_d;
  logic   w_mul_start;

  assign w_is_mul = (bus.ALUCtrl_i == AluMul);

  always_comb begin
    w_state_d   = r_state;
    w_mul_start = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept && w_is_mul) begin
          w_mul_start = 1'b1;
          w_state_d   = StMul;
        end
      end
      StMul: begin
        if (w_mul_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  assign bus.ready_o = (r_state == StIdle) && !rst_i;

  seq_alu_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (w_mul_start),
    .step_i    (r_state == StMul),
    .a_i       (bus.data1_i),
    .b_i       (bus.data2_i),
    .done_o    (w_mul_done),
    .product_o (w_product)
  );
`else
  assign w_is_mul    = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_product   = '0;
  assign bus.ready_o = !rst_i;
`endif

  assign w_accept = bus.valid_i && bus.ready_o;

  always_comb begin
    w_valid_d   = 1'b0;
    w_data_d    = r_data;
    w_zero_d    = r_zero;
    w_illegal_d = r_illegal;
    if (w_accept && !w_is_mul) begin
      w_valid_d   = 1'b1;
      w_data_d    = w_result;
      w_zero_d    = (w_result == '0);
      w_illegal_d = w_illegal;
    end else if (w_mul_done) begin
      w_valid_d   = 1'b1;
      w_data_d    = w_product;
      w_zero_d    = (w_product == '0);
      w_illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_valid   <= w_valid_d;
      r_data    <= w_data_d;
      r_zero    <= w_zero_d;
      r_illegal <= w_illegal_d;
    end
  end

  assign bus.valid_o   = r_valid;
  assign bus.data_o    = r_data;
  assign bus.zero_o    = r_zero;
  assign bus.illegal_o = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu; expectations follow SEQ_ALU_MUL_EN when it is defined.
module tb_seq_alu;

  localparam int unsigned WIDTH = 32;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpMul = 3'b011;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpBad = 3'b111;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        ill;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(
    .WIDTH (WIDTH)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] code, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    e.ill  = 1'b0;
    e.data = 32'h0;
    e.cyc  = 0;
    case (code)
      OpAdd: e.data = a + b;
      OpSub: e.data = a - b;
      OpAnd: e.data = a & b;
      OpOr:  e.data = a | b;
      OpMul: begin
        if (MulEn) e.data = a * b;
        else       e.ill  = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.data == 32'h0);
    return e;
  endfunction

  // Holds valid_i until accepted; waited counts rising edges spent including the accept edge.
  task automatic send(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                      input bit push, output int waited);
    exp_t e;
    bit   acc;
    e = model(code, a, b);
    acc = 1'b0;
    waited = 0;
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = code;
    bus.data1_i   = a;
    bus.data2_i   = b;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (bus.ready_o) begin
        acc = 1'b1;
        if (push) begin
          e.cyc = cyc + 1 + ((MulEn && code == OpMul) ? int'(WIDTH) : 0);
          sb.push_back(e);
        end
      end
      @(posedge clk);
      waited++;
    end
    #1 bus.valid_i = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (bus.valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("data", bus.data_o, mon_e.data);
        check("zero", {31'd0, bus.zero_o}, {31'd0, mon_e.zero});
        check("illegal", {31'd0, bus.illegal_o}, {31'd0, mon_e.ill});
        check("latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int busy;
    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = 32'h0;
    bus.data2_i   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", {31'd0, bus.ready_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_data", bus.data_o, 32'd0);
    check("rst_zero", {31'd0, bus.zero_o}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal_o}, 32'd0);
    @(posedge clk);
    #1;

    send(OpAdd, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, w);
    send(OpSub, 32'd5, 32'd5, 1'b1, w);
    send(OpAnd, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, w);
    check("b2b_and_wait", w, 32'd1);
    send(OpOr, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, w);
    check("b2b_or_wait", w, 32'd1);

    send(OpMul, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1, w);
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.ready_o) busy++;
      else break;
    end
    check("mul_busy_cycles", busy, MulEn ? WIDTH : 32'd0);
    @(posedge clk);
    #1;

    send(OpMul, 32'd6, 32'd7, 1'b1, w);
    send(OpAdd, 32'd1, 32'd2, 1'b1, w);
    check("held_valid_wait", w, MulEn ? WIDTH + 1 : 32'd1);

    send(OpBad, 32'd3, 32'd4, 1'b1, w);
    send(OpAdd, 32'd3, 32'd4, 1'b1, w);
    send(OpSub, 32'd3, 32'd10, 1'b1, w);

    // Abandoned multiply: no result expected when the multiplier exists.
    send(OpMul, 32'd6, 32'd7, !MulEn, w);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midmul_rst_ready", {31'd0, bus.ready_o}, 32'd0);
    @(negedge clk);
    check("midmul_valid", {31'd0, bus.valid_o}, 32'd0);
    check("midmul_data", bus.data_o, 32'd0);
    check("midmul_zero", {31'd0, bus.zero_o}, 32'd0);
    check("midmul_illegal", {31'd0, bus.illegal_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, bus.ready_o}, 32'd1);
    @(posedge clk);
    #1;
    send(OpMul, 32'd6, 32'd7, 1'b1, w);

    repeat (WIDTH + 5) @(posedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
